// File: rtl/md5_bf_job_ctrl.sv
// Job controller for one MD5_brute_force_3_symb engine: formats the padded block,
// sweeps the outer character across the printable range and returns one result record.
module md5_bf_job_ctrl #(
  parameter logic [7:0]  SYMB_LO      = 8'd32,
  parameter logic [7:0]  SYMB_HI      = 8'd126,
  parameter int          RST_CYCLES   = 4,
  parameter logic [31:0] PASS_TIMEOUT = 32'd50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [127:0] job_hash,
  input  logic [63:0]  job_prefix,
  input  logic [3:0]   job_prefix_len,
  input  logic         abort,
  output logic         eng_ce,
  output logic         eng_reset,
  output logic         eng_reset_zero_string,
  output logic [511:0] eng_start_str,
  output logic [31:0]  eng_a_hash,
  output logic [31:0]  eng_b_hash,
  output logic [31:0]  eng_c_hash,
  output logic [31:0]  eng_d_hash,
  input  logic         eng_find_str,
  input  logic [511:0] eng_result_str,
  input  logic         eng_symbols_done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic         res_error,
  output logic         res_aborted,
  output logic [511:0] res_str,
  output logic [6:0]   res_passes,
  output logic [2:0]   dbg_state
);

  // Handshakes: job and result transfer on the edge where valid && ready are both high;
  // the sender holds its payload stable until that edge.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_FORMAT  = 3'd2;
  localparam logic [2:0] S_RST_ENG = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;
  localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES);

  logic [2:0]   state_q, state_d;
  logic         job_ready_q, job_ready_d;
  logic [127:0] hash_q, hash_d;
  logic [63:0]  prefix_q, prefix_d;
  logic [3:0]   plen_q, plen_d;
  logic [7:0]   outer_q, outer_d;
  logic [7:0]   rst_cnt_q, rst_cnt_d;
  logic [31:0]  wd_q, wd_d;
  logic         eng_ce_q, eng_ce_d;
  logic         eng_rst_q, eng_rst_d;
  logic         eng_rzs_q, eng_rzs_d;
  logic [511:0] start_q, start_d;
  logic         res_valid_q, res_valid_d;
  logic         found_q, found_d;
  logic         error_q, error_d;
  logic         aborted_q, aborted_d;
  logic [511:0] res_str_q, res_str_d;
  logic [6:0]   passes_q, passes_d;
  logic         find_q, find_prev_q, done_q, done_prev_q;
  logic         find_rise, done_rise, to_report;
  logic [511:0] fmt;
  logic [7:0]   bit_len;

  assign find_rise = find_q & ~find_prev_q;
  assign done_rise = done_q & ~done_prev_q;
  // Message length in bits is (P+4)*8 = 8P+32; P is at most 8 here, so 8 bits suffice.
  assign bit_len = {1'b0, plen_q, 3'b000} + 8'd32;

  always_comb begin
    fmt = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(plen_q)) fmt[8*i +: 8] = prefix_q[8*i +: 8];
    end
    for (int i = 0; i < 13; i++) begin
      if (i == int'(plen_q)) fmt[8*i +: 8] = outer_q;
      else if (i > int'(plen_q) && i <= int'(plen_q) + 3) fmt[8*i +: 8] = SYMB_LO;
      else if (i == int'(plen_q) + 4) fmt[8*i +: 8] = 8'h80;
    end
    fmt[455:448] = bit_len;
  end

  always_comb begin
    state_d     = state_q;
    job_ready_d = job_ready_q;
    hash_d      = hash_q;
    prefix_d    = prefix_q;
    plen_d      = plen_q;
    outer_d     = outer_q;
    rst_cnt_d   = rst_cnt_q;
    wd_d        = wd_q;
    eng_ce_d    = eng_ce_q;
    eng_rst_d   = eng_rst_q;
    eng_rzs_d   = eng_rzs_q;
    start_d     = start_q;
    res_valid_d = res_valid_q;
    found_d     = found_q;
    error_d     = error_q;
    aborted_d   = aborted_q;
    res_str_d   = res_str_q;
    passes_d    = passes_q;
    to_report   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready_q) begin
          hash_d      = job_hash;
          prefix_d    = job_prefix;
          plen_d      = job_prefix_len;
          outer_d     = SYMB_LO;
          job_ready_d = 1'b0;
          found_d     = 1'b0;
          error_d     = 1'b0;
          aborted_d   = 1'b0;
          res_str_d   = '0;
          passes_d    = '0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          aborted_d = 1'b1;
          to_report = 1'b1;
        end else if (plen_q > 4'd8) begin
          error_d   = 1'b1;
          to_report = 1'b1;
        end else begin
          state_d = S_FORMAT;
        end
      end
      S_FORMAT: begin
        if (abort) begin
          aborted_d = 1'b1;
          to_report = 1'b1;
        end else begin
          start_d   = fmt;
          rst_cnt_d = '0;
          state_d   = S_RST_ENG;
        end
      end
      S_RST_ENG: begin
        if (abort) begin
          aborted_d = 1'b1;
          to_report = 1'b1;
        end else if (rst_cnt_q == RST_LAST) begin
          eng_ce_d  = 1'b1;
          eng_rst_d = 1'b0;
          eng_rzs_d = 1'b0;
          wd_d      = '0;
          state_d   = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          to_report = 1'b1;
        end else if (find_rise) begin
          // A coincident done still counts the pass that produced the hit.
          res_str_d = eng_result_str;
          found_d   = 1'b1;
          if (done_rise) passes_d = passes_q + 7'd1;
          to_report = 1'b1;
        end else if (done_rise) begin
          passes_d = passes_q + 7'd1;
          if (outer_q < SYMB_HI) begin
            outer_d   = outer_q + 8'd1;
            eng_ce_d  = 1'b0;
            eng_rst_d = 1'b1;
            eng_rzs_d = 1'b1;
            state_d   = S_FORMAT;
          end else begin
            to_report = 1'b1;
          end
        end else if (wd_q + 32'd1 == PASS_TIMEOUT) begin
          error_d   = 1'b1;
          to_report = 1'b1;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          job_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (to_report) begin
      state_d     = S_REPORT;
      res_valid_d = 1'b1;
      eng_ce_d    = 1'b0;
      eng_rst_d   = 1'b1;
      eng_rzs_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_ready_q <= 1'b1;
      hash_q      <= '0;
      prefix_q    <= '0;
      plen_q      <= '0;
      outer_q     <= '0;
      rst_cnt_q   <= '0;
      wd_q        <= '0;
      eng_ce_q    <= 1'b0;
      eng_rst_q   <= 1'b1;
      eng_rzs_q   <= 1'b1;
      start_q     <= '0;
      res_valid_q <= 1'b0;
      found_q     <= 1'b0;
      error_q     <= 1'b0;
      aborted_q   <= 1'b0;
      res_str_q   <= '0;
      passes_q    <= '0;
      find_q      <= 1'b0;
      find_prev_q <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_ready_q <= job_ready_d;
      hash_q      <= hash_d;
      prefix_q    <= prefix_d;
      plen_q      <= plen_d;
      outer_q     <= outer_d;
      rst_cnt_q   <= rst_cnt_d;
      wd_q        <= wd_d;
      eng_ce_q    <= eng_ce_d;
      eng_rst_q   <= eng_rst_d;
      eng_rzs_q   <= eng_rzs_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      found_q     <= found_d;
      error_q     <= error_d;
      aborted_q   <= aborted_d;
      res_str_q   <= res_str_d;
      passes_q    <= passes_d;
      find_q      <= eng_find_str;
      find_prev_q <= find_q;
      done_q      <= eng_symbols_done;
      done_prev_q <= done_q;
    end
  end

  assign job_ready             = job_ready_q;
  assign eng_ce                = eng_ce_q;
  assign eng_reset             = eng_rst_q;
  assign eng_reset_zero_string = eng_rzs_q;
  assign eng_start_str         = start_q;
  assign eng_a_hash            = hash_q[127:96];
  assign eng_b_hash            = hash_q[95:64];
  assign eng_c_hash            = hash_q[63:32];
  assign eng_d_hash            = hash_q[31:0];
  assign res_valid             = res_valid_q;
  assign res_found             = found_q;
  assign res_error             = error_q;
  assign res_aborted           = aborted_q;
  assign res_str               = res_str_q;
  assign res_passes            = passes_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_md5_bf_job_ctrl.sv
// Bench for md5_bf_job_ctrl: a stub engine answers each pass, a table plus random jobs
// are compared with an outcome model, and hand sequences cover abort, reset and backpressure.
module tb_md5_bf_job_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         job_valid = 1'b0, job_ready;
  logic [127:0] job_hash = '0;
  logic [63:0]  job_prefix = '0;
  logic [3:0]   job_prefix_len = '0;
  logic         abort = 1'b0;
  logic         eng_ce, eng_reset, eng_reset_zero_string;
  logic [511:0] eng_start_str;
  logic [31:0]  eng_a_hash, eng_b_hash, eng_c_hash, eng_d_hash;
  logic         eng_find_str = 1'b0;
  logic [511:0] eng_result_str = '0;
  logic         eng_symbols_done = 1'b0;
  logic         res_valid, res_ready = 1'b0;
  logic         res_found, res_error, res_aborted;
  logic [511:0] res_str;
  logic [6:0]   res_passes;
  logic [2:0]   dbg_state;

  md5_bf_job_ctrl #(.PASS_TIMEOUT(32'd100)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_hash(job_hash), .job_prefix(job_prefix), .job_prefix_len(job_prefix_len),
    .abort(abort), .eng_ce(eng_ce), .eng_reset(eng_reset),
    .eng_reset_zero_string(eng_reset_zero_string), .eng_start_str(eng_start_str),
    .eng_a_hash(eng_a_hash), .eng_b_hash(eng_b_hash), .eng_c_hash(eng_c_hash),
    .eng_d_hash(eng_d_hash), .eng_find_str(eng_find_str), .eng_result_str(eng_result_str),
    .eng_symbols_done(eng_symbols_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_error(res_error), .res_aborted(res_aborted),
    .res_str(res_str), .res_passes(res_passes), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, pass_idx = 0, run_cnt = 0;
  int find_cyc = -1, ce_rise_cyc = -1, rv_rise_cyc = -1;
  logic ce_prev = 1'b0, rv_prev = 1'b0;
  int stub_find_pass = 0, stub_find_at = 0, stub_done_at = 0;
  logic [511:0] stub_block = '0;
  logic [511:0] got_q[$];
  logic [511:0] exp_q[$];

  typedef struct {
    logic [3:0]  p;
    logic [63:0] pre;
    int          fpass, fat, dat;
    logic        e_found, e_err;
    int          e_passes, e_runs;
  } vec_t;
  vec_t vecs[6];

  // Stub engine: counts enabled cycles per pass, pulses done/find, logs the block of each pass.
  initial forever begin
    @(negedge clk);
    cyc++;
    eng_find_str = 1'b0;
    eng_symbols_done = 1'b0;
    if (job_ready) begin
      pass_idx = 0;
      got_q.delete();
    end
    if (eng_ce) begin
      if (!ce_prev) begin
        pass_idx++;
        run_cnt = 0;
        ce_rise_cyc = cyc;
        got_q.push_back(eng_start_str);
      end
      run_cnt++;
      if (stub_done_at != 0 && run_cnt == stub_done_at) eng_symbols_done = 1'b1;
      if (stub_find_pass == pass_idx && run_cnt == stub_find_at) begin
        eng_find_str = 1'b1;
        eng_result_str = stub_block;
        find_cyc = cyc;
      end
    end
    if (res_valid && !rv_prev) rv_rise_cyc = cyc;
    ce_prev = eng_ce;
    rv_prev = res_valid;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] model_block(input logic [63:0] pre, input int p, input int o);
    logic [7:0] b [64];
    logic [511:0] r;
    int bits;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < p; i++) b[i] = pre[8*i +: 8];
    b[p] = 8'(o);
    for (int i = 1; i <= 3; i++) b[p+i] = 8'd32;
    b[p+4] = 8'h80;
    bits = (p + 4) * 8;
    for (int i = 0; i < 8; i++) b[56+i] = 8'(bits >> (8*i));
    for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  // Walks the sweep pass by pass: hit if the find lands before the pass ends, timeout if no done.
  task automatic model_outcome(input int p, input int fpass, input int fat, input int dat,
                               output logic found, output logic err, output int passes, output int runs);
    int limit;
    found = 1'b0; err = 1'b0; passes = 0; runs = 0;
    limit = (dat == 0 || dat > 99) ? 99 : dat;
    if (p > 8) err = 1'b1;
    else for (int ps = 1; ps <= 95; ps++) begin
      runs = ps;
      if (ps == fpass && fat >= 1 && fat <= limit) begin
        found = 1'b1;
        passes = ps - 1 + ((dat == fat) ? 1 : 0);
        break;
      end
      if (dat == 0 || dat > 99) begin
        err = 1'b1;
        passes = ps - 1;
        break;
      end
      passes = ps;
    end
  endtask

  task automatic send_job(input logic [127:0] h, input logic [63:0] pre, input logic [3:0] p, output int t0);
    int n = 0;
    while (!job_ready && n < 200) begin tick(); n++; end
    job_hash = h; job_prefix = pre; job_prefix_len = p; job_valid = 1'b1;
    t0 = cyc;
    tick();
    job_valid = 1'b0;
    chk("accept", 512'(job_ready), 512'd0);
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin tick(); n++; end
    chk("res_valid_seen", 512'(res_valid), 512'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", 512'(res_valid), 512'd0);
    chk("job_ready_back", 512'(job_ready), 512'd1);
  endtask

  task automatic run_job(input string tag, input logic [3:0] p, input logic [63:0] pre,
                         input logic [127:0] h, input int fpass, input int fat, input int dat,
                         input logic [511:0] blk, input logic e_found, input logic e_err,
                         input int e_passes, input int e_runs);
    int t0, n;
    exp_q.delete();
    for (int k = 0; k < e_runs; k++) exp_q.push_back(model_block(pre, int'(p), 32 + k));
    stub_find_pass = fpass; stub_find_at = fat; stub_done_at = dat; stub_block = blk;
    send_job(h, pre, p, t0);
    wait_res(96 * (((dat > 100) ? dat : 100) + 10) + 50);
    chk({tag, "_found"}, 512'(res_found), 512'(e_found));
    chk({tag, "_error"}, 512'(res_error), 512'(e_err));
    chk({tag, "_aborted"}, 512'(res_aborted), 512'd0);
    chk({tag, "_passes"}, 512'(res_passes), 512'(e_passes));
    chk({tag, "_str"}, res_str, e_found ? blk : 512'd0);
    chk({tag, "_hash"}, 512'({eng_a_hash, eng_b_hash, eng_c_hash, eng_d_hash}), 512'(h));
    chk({tag, "_ce_off"}, 512'({eng_ce, eng_reset}), 512'(2'b01));
    chk({tag, "_runs"}, 512'(got_q.size()), 512'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk({tag, "_block"}, got_q[k], exp_q[k]);
    if (e_found) chk({tag, "_find_lat"}, 512'(rv_rise_cyc - find_cyc), 512'd2);
    else if (e_err && p > 4'd8) chk({tag, "_len_lat"}, 512'(rv_rise_cyc - t0), 512'd2);
    else if (e_err) chk({tag, "_wd_lat"}, 512'(rv_rise_cyc - ce_rise_cyc), 512'd100);
    consume();
  endtask

  initial begin
    logic [511:0] blk, g, snap_str;
    logic [9:0] snap_flags;
    logic m_found, m_err, seen, unstable;
    int m_passes, m_runs, t0, n, p, fp, fa, da;

    vecs[0] = '{4'd2, 64'hdead_beef_0000_6261, 1, 10, 0, 1'b1, 1'b0, 0, 1};
    vecs[1] = '{4'd9, 64'h1122_3344_5566_7788, 1, 10, 20, 1'b0, 1'b1, 0, 0};
    vecs[2] = '{4'd3, 64'h0000_0000_007a_7978, 1, 20, 20, 1'b1, 1'b0, 1, 1};
    vecs[3] = '{4'd8, 64'h3736_3534_3332_3130, 4, 5, 12, 1'b1, 1'b0, 3, 4};
    vecs[4] = '{4'd1, 64'hffff_ffff_ffff_ff71, 0, 0, 0, 1'b0, 1'b1, 0, 1};
    vecs[5] = '{4'd5, 64'h0000_006f_6c6c_6568, 2, 30, 25, 1'b0, 1'b0, 95, 95};

    // Reset values, checked while reset is held and just after release.
    repeat (3) tick();
    chk("rst_job_ready", 512'(job_ready), 512'd1);
    chk("rst_res_valid", 512'(res_valid), 512'd0);
    chk("rst_eng_ctl", 512'({eng_ce, eng_reset, eng_reset_zero_string}), 512'(3'b011));
    chk("rst_start_str", eng_start_str, 512'd0);
    chk("rst_hash", 512'({eng_a_hash, eng_b_hash, eng_c_hash, eng_d_hash}), 512'd0);
    chk("rst_res_flags", 512'({res_found, res_error, res_aborted, res_passes}), 512'd0);
    chk("rst_res_str", res_str, 512'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 512'(job_ready), 512'd1);

    // Table vectors; vector 0 returns the "ab ~xy" block.
    for (int v = 0; v < 6; v++) begin
      if (v == 0) begin
        blk = '0;
        blk[55:0] = 56'h80_7978_7e20_6261;
        blk[455:448] = 8'd48;
      end else for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
      run_job($sformatf("vec%0d", v), vecs[v].p, vecs[v].pre,
              {$urandom(), $urandom(), $urandom(), $urandom()},
              vecs[v].fpass, vecs[v].fat, vecs[v].dat, blk,
              vecs[v].e_found, vecs[v].e_err, vecs[v].e_passes, vecs[v].e_runs);
    end

    // Full sweep with P=0: the outer byte walks 32..126 under a fixed seed/pad/length.
    stub_find_pass = 0; stub_find_at = 0; stub_done_at = 20;
    send_job(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 64'h0, 4'd0, t0);
    wait_res(4000);
    chk("sweep_passes", 512'(res_passes), 512'd95);
    chk("sweep_found", 512'({res_found, res_error}), 512'd0);
    chk("sweep_count", 512'(got_q.size()), 512'd95);
    for (int k = 0; k < got_q.size(); k++) begin
      g = got_q[k];
      chk("sweep_byte0", 512'(g[7:0]), 512'(32 + k));
      chk("sweep_fixed", 512'({g[39:8], g[455:448]}), 512'({8'h80, 8'd32, 8'd32, 8'd32, 8'd32}));
    end
    consume();

    // Abort during pass 3.
    stub_find_pass = 0; stub_done_at = 20;
    send_job(128'h5, 64'h41, 4'd1, t0);
    n = 0;
    while (pass_idx != 3 && n < 500) begin tick(); n++; end
    repeat (5) tick();
    abort = 1'b1;
    wait_res(50);
    abort = 1'b0;
    chk("abort_flags", 512'({res_aborted, res_found, res_error}), 512'(3'b100));
    chk("abort_passes", 512'(res_passes), 512'd2);
    consume();

    // Reset in the middle of a pass.
    stub_find_pass = 0; stub_done_at = 0;
    send_job(128'h7, 64'h6261, 4'd2, t0);
    n = 0;
    while (!eng_ce && n < 50) begin tick(); n++; end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midrst_ctl", 512'({eng_ce, job_ready, res_valid}), 512'(3'b010));
    reset = 1'b0;
    seen = 1'b0;
    repeat (200) begin tick(); if (res_valid) seen = 1'b1; end
    chk("midrst_no_res", 512'(seen), 512'd0);

    // Result held under backpressure.
    for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
    stub_find_pass = 1; stub_find_at = 10; stub_done_at = 0; stub_block = blk;
    send_job(128'h9, 64'h6261, 4'd2, t0);
    wait_res(200);
    snap_flags = {res_found, res_error, res_aborted, res_passes};
    snap_str = res_str;
    unstable = 1'b0;
    repeat (50) begin
      tick();
      if ({res_found, res_error, res_aborted, res_passes} !== snap_flags || res_str !== snap_str ||
          job_ready !== 1'b0 || res_valid !== 1'b1) unstable = 1'b1;
    end
    chk("bp_stable", 512'(unstable), 512'd0);
    chk("bp_result", {res_str[501:0], snap_flags}, {blk[501:0], 10'b1000000000});
    consume();

    // Random jobs against the outcome model.
    for (int r = 0; r < 4; r++) begin
      p  = $urandom_range(0, 9);
      da = $urandom_range(15, 40);
      fp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
      fa = $urandom_range(1, 45);
      for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
      model_outcome(p, fp, fa, da, m_found, m_err, m_passes, m_runs);
      run_job($sformatf("rnd%0d", r), 4'(p), {$urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()},
              fp, fa, da, blk, m_found, m_err, m_passes, m_runs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
